// File: rtl/cam_i2c_write_master_pkg.sv
// Shared definitions for the camera I2C write master: FSM states, default
// sensor addresses and the bit-phase (quarter-period) constants.
package cam_i2c_write_master_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        DATA,
        ACK,
        LOAD,
        STOP,
        DRAIN,
        DONE
    } cam_state_t;

    localparam int unsigned DEF_CLK_DIV   = 125;
    localparam logic [6:0]  DEF_DEV_ADDR0 = 7'h48;
    localparam logic [6:0]  DEF_DEV_ADDR1 = 7'h5D;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Index of the LSB within a reg/MSB/LSB triplet.
    localparam logic [1:0] LAST_IDX = 2'd2;

endpackage

// File: rtl/cam_i2c_tick_gen.sv
// Quarter-period tick generator: one-cycle tick every CLK_DIV sysClk cycles
// while enabled; restarts from zero whenever disabled.
module cam_i2c_tick_gen #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic sysClk,
    input  logic rstn,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge sysClk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cam_i2c_write_master.sv
// Camera sensor I2C write master: turns reg/MSB/LSB byte triplets into
// one I2C register write each, with NACK and malformed-burst handling.
module cam_i2c_write_master
    import cam_i2c_write_master_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter logic [6:0]  DEV_ADDR0 = DEF_DEV_ADDR0,
    parameter logic [6:0]  DEV_ADDR1 = DEF_DEV_ADDR1
) (
    input  logic       sysClk,
    input  logic       rstn,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       byte_last,
    input  logic       cam_id,
    output logic       byte_ready,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic       busy,
    output logic       done,
    output logic       nack_err
);

    cam_state_t state, state_n;

    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic [1:0] byte_cnt;
    logic [7:0] shreg;
    logic       cam_sel;
    logic       last_seen;
    logic       abort;
    logic       in_addr;
    logic       ack_bit;
    logic       rdy_en;
    logic       rdy_st;
    logic       tick_en;
    logic       tick;
    logic       accept;
    logic       ack_end;
    logic [7:0] tx_byte;
    logic       tx_bit;

    cam_i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .sysClk (sysClk),
        .rstn   (rstn),
        .en     (tick_en),
        .tick   (tick)
    );

    assign byte_ready = rdy_en && rdy_st;
    assign accept     = byte_valid && byte_ready;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign ack_end    = (state == ACK) && tick && (phase == Q3);
    assign tx_byte    = (state == ADDR) ? {(cam_sel ? DEV_ADDR1 : DEV_ADDR0), 1'b0} : shreg;
    assign tx_bit     = tx_byte[3'd7 - bit_cnt];

    always_ff @(posedge sysClk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        scl_oe  = 1'b0;
        sda_oe  = 1'b0;
        rdy_st  = 1'b0;
        tick_en = 1'b0;
        case (state)
            IDLE: begin
                rdy_st = 1'b1;
                if (accept) state_n = START;
            end
            START: begin
                tick_en = 1'b1;
                sda_oe  = 1'b1;
                scl_oe  = (phase == Q2);
                if (tick && phase == Q2) state_n = ADDR;
            end
            ADDR, DATA: begin
                tick_en = 1'b1;
                sda_oe  = ~tx_bit;
                scl_oe  = (phase == Q0) || (phase == Q3);
                if (tick && phase == Q3 && bit_cnt == 3'd7) state_n = ACK;
            end
            ACK: begin
                tick_en = 1'b1;
                scl_oe  = (phase == Q0) || (phase == Q3);
                if (ack_end) begin
                    if (ack_bit)                             state_n = STOP;
                    else if (in_addr)                        state_n = DATA;
                    else if (last_seen || byte_cnt == LAST_IDX) state_n = STOP;
                    else                                     state_n = LOAD;
                end
            end
            LOAD: begin
                // byte_cnt==LAST_IDX here means a STOP already freed the bus
                // and the next triplet's reg byte is awaited.
                rdy_st = 1'b1;
                scl_oe = (byte_cnt != LAST_IDX);
                if (accept) state_n = (byte_cnt == LAST_IDX) ? START : DATA;
            end
            STOP: begin
                tick_en = 1'b1;
                sda_oe  = (phase == Q0) || (phase == Q1);
                scl_oe  = (phase == Q0);
                if (tick && phase == Q3) begin
                    if (last_seen)  state_n = DONE;
                    else if (abort) state_n = DRAIN;
                    else            state_n = LOAD;
                end
            end
            DRAIN: begin
                rdy_st = 1'b1;
                if (accept && byte_last) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sysClk or negedge rstn) begin
        if (!rstn) begin
            phase     <= Q0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
            cam_sel   <= 1'b0;
            last_seen <= 1'b0;
            abort     <= 1'b0;
            in_addr   <= 1'b0;
            ack_bit   <= 1'b0;
            nack_err  <= 1'b0;
            rdy_en    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (state_n != state || !tick_en) begin
                phase <= Q0;
            end else if (tick) begin
                phase <= phase + 2'd1;
            end
            if ((state == ADDR || state == DATA) && tick && phase == Q3) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state == ACK && tick && phase == Q2) begin
                ack_bit <= sda_in;
            end
            if (state == START) begin
                in_addr <= 1'b1;
            end
            if (ack_end) begin
                in_addr <= 1'b0;
                if (ack_bit) begin
                    nack_err <= 1'b1;
                    abort    <= 1'b1;
                end else if (!in_addr && last_seen && byte_cnt != LAST_IDX) begin
                    nack_err <= 1'b1;
                end
            end
            if (accept) begin
                shreg <= byte_in;
                if (state == IDLE) begin
                    byte_cnt  <= '0;
                    cam_sel   <= cam_id;
                    last_seen <= byte_last;
                    abort     <= 1'b0;
                    nack_err  <= 1'b0;
                end else if (state == LOAD) begin
                    last_seen <= byte_last;
                    if (byte_cnt == LAST_IDX) begin
                        byte_cnt <= '0;
                        cam_sel  <= cam_id;
                    end else begin
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_i2c_write_master.sv
// Scoreboard bench: a bus-level reference model predicts START/byte/STOP/done
// events per burst; a bus monitor with an ACKing slave compares them.
module tb_cam_i2c_write_master;

    localparam int TOK_S = 256;
    localparam int TOK_P = 512;
    localparam int TOK_D = 768;

    logic       sysClk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] byte_in = '0;
    logic       byte_valid = 1'b0;
    logic       byte_last = 1'b0;
    logic       cam_id = 1'b0;
    logic       byte_ready;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_in;
    logic       busy;
    logic       done;
    logic       nack_err;
    logic       slave_pull = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int bq[$];
    int cq[$];
    int nack_idx = -1;

    assign sda_in = ~(sda_oe | slave_pull);

    cam_i2c_write_master #(.CLK_DIV(4), .DEV_ADDR0(7'h48), .DEV_ADDR1(7'h5D)) dut (
        .sysClk     (sysClk),
        .rstn       (rstn),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .cam_id     (cam_id),
        .byte_ready (byte_ready),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .sda_in     (sda_in),
        .busy       (busy),
        .done       (done),
        .nack_err   (nack_err)
    );

    always #5 sysClk = ~sysClk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input int obs);
        int e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h, expected nothing (queue empty)", name, obs);
        end else begin
            e = exp_q.pop_front();
            check(name, obs, e);
        end
    endtask

    // Reference: each triplet is S, addr, up to three data bytes, P; a NACKed
    // byte or a burst ending mid-triplet cuts it short and flags an error.
    task automatic model(input int n, input int nack_at);
        int  sent;
        int  idx;
        bit  err;
        bit  fin;
        sent = 0;
        err  = 0;
        fin  = 0;
        for (int t = 0; t * 3 < n && !fin; t++) begin
            exp_q.push_back(TOK_S);
            exp_q.push_back((cq[t * 3] != 0) ? (8'h5D * 2) : (8'h48 * 2));
            if (sent == nack_at) begin err = 1; fin = 1; end
            sent++;
            for (int j = 0; j < 3 && !fin; j++) begin
                idx = t * 3 + j;
                exp_q.push_back(bq[idx]);
                if (sent == nack_at) begin err = 1; fin = 1; end
                else if (idx == n - 1 && j < 2) begin err = 1; fin = 1; end
                sent++;
            end
            exp_q.push_back(TOK_P);
        end
        exp_q.push_back(TOK_D + int'(err));
    endtask

    task automatic monitor();
        bit         p_scl, p_sda, scl, sda, in_frame;
        int         bitcnt, slv_byte;
        logic [7:0] shb;
        p_scl = 1; p_sda = 1; in_frame = 0; bitcnt = 0; slv_byte = 0; shb = '0;
        forever begin
            @(negedge sysClk);
            if (!rstn) begin
                p_scl = 1; p_sda = 1; in_frame = 0; bitcnt = 0; slv_byte = 0;
                slave_pull = 1'b0;
            end else begin
                scl = !scl_oe;
                sda = !(sda_oe || slave_pull);
                if (p_scl && scl && p_sda && !sda) begin
                    in_frame = 1; bitcnt = 0;
                    sb_check("start", TOK_S);
                end else if (p_scl && scl && !p_sda && sda) begin
                    in_frame = 0;
                    sb_check("stop", TOK_P);
                end else if (!p_scl && scl && in_frame) begin
                    if (bitcnt < 8) shb = {shb[6:0], sda};
                    bitcnt++;
                    if (bitcnt == 9) begin
                        sb_check("byte", int'(shb));
                        bitcnt = 0;
                        slv_byte++;
                    end
                end else if (p_scl && !scl && in_frame) begin
                    slave_pull = (bitcnt == 8) && (slv_byte != nack_idx);
                end
                if (done) begin
                    sb_check("done", TOK_D + int'(nack_err));
                    slv_byte = 0;
                end
                p_scl = scl;
                p_sda = sda;
            end
        end
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic last, input logic cam);
        int w;
        repeat ($urandom_range(0, 3)) @(negedge sysClk);
        byte_in = b; byte_last = last; cam_id = cam; byte_valid = 1'b1;
        w = 0;
        while (!byte_ready && w < 20000) begin @(negedge sysClk); w++; end
        if (!byte_ready) check("handshake_timeout", int'(byte_ready), 1);
        else @(posedge sysClk);
        #1 byte_valid = 1'b0; byte_last = 1'b0;
        @(negedge sysClk);
    endtask

    task automatic release_reset();
        repeat (3) @(negedge sysClk);
        rstn = 1'b1;
        #1 check("ready_before_edge", int'(byte_ready), 0);
        @(posedge sysClk);
        #1 check("ready_after_edge", int'(byte_ready), 1);
        @(negedge sysClk);
    endtask

    task automatic mid_reset();
        repeat (50) @(posedge sysClk);
        #1 rstn = 1'b0;
        #1;
        check("rst_scl_oe", int'(scl_oe), 0);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(byte_ready), 0);
        @(negedge sysClk);
        exp_q.delete();
        nack_idx = -1;
        release_reset();
    endtask

    task automatic fill(input int n, input int cam_mode);
        bq.delete(); cq.delete();
        for (int i = 0; i < n; i++) begin
            bq.push_back(int'($urandom_range(0, 255)));
            cq.push_back((cam_mode < 0) ? int'($urandom_range(0, 1)) : cam_mode);
        end
    endtask

    task automatic run_burst(input int n, input int nack_at, input int gap_idx, input int rst_idx);
        int w, hi;
        nack_idx = nack_at;
        model(n, nack_at);
        for (int i = 0; i < n; i++) begin
            if (i == gap_idx) begin
                w = 0;
                while (!byte_ready && w < 20000) begin @(negedge sysClk); w++; end
                hi = 0;
                repeat (500) begin
                    @(negedge sysClk);
                    if (!scl_oe) hi++;
                end
                check("scl_held_low_cycles_released", hi, 0);
            end
            drive_byte(8'(bq[i]), (i == n - 1), 1'(cq[i]));
            if (i == rst_idx) begin
                mid_reset();
                return;
            end
        end
        w = 0;
        while (exp_q.size() != 0 && w < 40000) begin @(negedge sysClk); w++; end
        check("burst_events_left", exp_q.size(), 0);
        exp_q.delete();
        @(negedge sysClk);
        check("idle_busy", int'(busy), 0);
        nack_idx = -1;
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (2) @(negedge sysClk);
        check("reset_scl_oe", int'(scl_oe), 0);
        check("reset_sda_oe", int'(sda_oe), 0);
        check("reset_ready", int'(byte_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_nack_err", int'(nack_err), 0);
        release_reset();

        // single write, cam 0
        bq = '{8'h08, 8'h00, 8'h05};
        cq = '{0, 0, 0};
        run_burst(3, -1, -1, -1);

        // seven triplets, cam 1
        fill(21, 1);
        run_burst(21, -1, -1, -1);

        // NACK on reg byte of triplet 2 of 3
        fill(9, -1);
        run_burst(9, 5, -1, -1);

        // long stall before the MSB
        fill(3, -1);
        run_burst(3, -1, 1, -1);

        // reset while MSB bits are on the wire, then a clean burst
        fill(3, 0);
        bq[1] = 8'h00;
        run_burst(3, -1, -1, 1);
        fill(3, -1);
        run_burst(3, -1, -1, -1);

        // burst ends on triplet byte 1
        fill(2, -1);
        run_burst(2, -1, -1, -1);

        for (int k = 0; k < 6; k++) begin
            int n;
            int na;
            n  = int'($urandom_range(1, 9));
            na = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1;
            fill(n, -1);
            run_burst(n, na, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_i2c_write_master.md
CAM_I2C_WRITE_MASTER -- requirements
Module: cam_i2c_write_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, meaning sysClk cycles per SCL quarter-period (100 kHz SCL at 50 MHz).
REQ-002 SHALL have parameter DEV_ADDR0, default 7'h48, meaning the 7-bit sensor address used when cam_id=0.
REQ-003 SHALL have parameter DEV_ADDR1, default 7'h5D, meaning the 7-bit sensor address used when cam_id=1.
REQ-004 SHALL have port sysClk, input, width 1: the single clock.
REQ-005 SHALL have port rstn, input, width 1: asynchronous active-low reset.
REQ-006 SHALL have port byte_in, input, width 8: command stream byte, as a triplet of reg addr, data[15:8], data[7:0].
REQ-007 SHALL have port byte_valid, input, width 1: byte_in, byte_last and cam_id are valid.
REQ-008 SHALL have port byte_last, input, width 1: final byte of the command burst.
REQ-009 SHALL have port cam_id, input, width 1: target sensor select.
REQ-010 SHALL have port byte_ready, output, width 1: ready_for_next_byte to the command producer.
REQ-011 SHALL have port scl_oe, output, width 1: 1 = pull SCL low, 0 = release.
REQ-012 SHALL have port sda_oe, output, width 1: 1 = pull SDA low, 0 = release.
REQ-013 SHALL have port sda_in, input, width 1: synchronized SDA level.
REQ-014 SHALL have port busy, output, width 1: a burst is in progress.
REQ-015 SHALL have port done, output, width 1: one-cycle pulse at the end of a burst.
REQ-016 SHALL have port nack_err, output, width 1: sticky error flag, cleared on the first accepted byte of the next burst.

Function
REQ-017 A byte SHALL be accepted on any sysClk edge where byte_valid and byte_ready are both 1.
REQ-018 byte_ready SHALL be 1 only in IDLE and LOAD, and in DRAIN.
REQ-019 FSM states SHALL be IDLE, START, ADDR, DATA, ACK, LOAD, STOP, DRAIN, DONE.
REQ-020 Each triplet SHALL produce exactly one I2C write: START, device address with write bit (0) + ACK, reg + ACK, MSB + ACK, LSB + ACK, STOP.
REQ-021 cam_id SHALL be sampled with the first byte of each triplet; the address byte SHALL be {DEV_ADDRx, 1'b0}.
REQ-022 Each bit SHALL occupy four quarter-periods.
  - Q0: SCL low; SDA updated.
  - Q1 and Q2: SCL released.
  - Sample sda_in in the last cycle of Q2.
  - Q3: SCL low.
REQ-023 Bits SHALL be sent MSB first; a 0 bit SHALL set sda_oe=1, a 1 bit SHALL set sda_oe=0.
REQ-024 START SHALL pull SDA low while SCL is released for 2 quarters, then pull SCL low.
REQ-025 STOP SHALL hold SDA low with SCL released for 1 quarter, then release SDA for 2 quarters.
REQ-026 A 3-bit bit counter and a 2-bit triplet byte counter (0..2, wraps to 0) SHALL track progress.
REQ-027 The quarter counter SHALL count 0..CLK_DIV-1 and then advance the phase.
REQ-028 After each data ACK, LOAD SHALL wait indefinitely for the next byte with SCL held low; no timeout.
REQ-029 After the LSB ACK, the FSM SHALL go to STOP, then to START if more bytes follow, else to DONE.
REQ-030 On a sampled ACK of 1 (NACK), the FSM SHALL set nack_err and go to STOP.
  - Then DRAIN, accepting and discarding bytes until byte_last is accepted.
  - If byte_last was already accepted, go straight to DONE.
REQ-031 If byte_last arrives on triplet byte 0 or 1, that byte SHALL be sent, then STOP and DONE, with nack_err set as a format error.
REQ-032 DONE SHALL pulse done for 1 cycle and return to IDLE.
REQ-033 busy SHALL be 1 in all states except IDLE.
REQ-034 Clock stretching SHALL NOT be supported; SCL is never read back.

Reset
REQ-035 While rstn=0, the block SHALL hold: state IDLE, scl_oe=0, sda_oe=0, byte_ready=0, busy=0, done=0, nack_err=0, and all counters 0.
REQ-036 byte_ready SHALL rise on the first sysClk edge after rstn deasserts.
REQ-037 Reset during a transfer SHALL release the bus immediately; a partial transfer SHALL NOT resume.

Structure
REQ-038 The FSM state encoding, the default DEV_ADDR values and the phase constants SHALL live in the shared cam package.
REQ-039 The quarter-period tick generator SHALL be one sub-module, cam_i2c_tick_gen, with CLK_DIV as its parameter.

Verification
REQ-040 Single write: cam_id=0, bytes 08,00,05 with last on 05, slave ACKs all.
  - Bus shows START, 0x90, 0x08, 0x00, 0x05, STOP.
  - done pulses once; nack_err=0.
REQ-041 Seven triplets with cam_id=1: address byte 0xBA; seven START/STOP pairs; done once at the end.
REQ-042 Slave NACKs the reg byte of triplet 2 of 3: STOP follows that ACK slot, the remaining bytes are drained, done pulses, nack_err=1.
REQ-043 byte_valid is withheld for 500 cycles before the MSB: SCL is held low throughout, and the transfer completes correctly.
REQ-044 rstn pulsed during the MSB bits: scl_oe=0 and sda_oe=0 in the same cycle, then IDLE; the next burst starts with a clean START.
REQ-045 byte_last on triplet byte 1: reg and MSB are sent, then STOP; nack_err=1; done pulses.
